// File: rtl/smart_home_sensor_cond.sv
// Sensor conditioning front end: contact debounce, fire-alarm hold logic and
// a 4-sample moving-average temperature filter with plausibility checking.

module sensor_deb #(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic s,
  output logic q
);
  localparam logic [3:0] LAST = 4'(DEB_CYCLES - 1);

  logic [3:0] cnt;

  // For a 1-bit level, any change of s while counting lands back on q,
  // so the equality clear also covers the "input changed" clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      q   <= 1'b0;
    end else if (s == q) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      q   <= s;
      cnt <= '0;
    end else begin
      cnt <= cnt + 4'd1;
    end
  end
endmodule

module smart_home_sensor_cond #(
  parameter int DEB_CYCLES = 4,
  parameter int FA_DEB     = 2,
  parameter int FA_HOLD    = 16,
  parameter int T_MAX      = 100,
  parameter int T_INIT     = 60
) (
  input  logic       clk,
  input  logic       Rst,
  input  logic       raw_fd,
  input  logic       raw_rd,
  input  logic       raw_w,
  input  logic       raw_fa,
  input  logic [6:0] raw_temp,
  input  logic       temp_valid,
  output logic       SFD,
  output logic       SRD,
  output logic       SW,
  output logic       SFA,
  output logic [6:0] ST,
  output logic       temp_fault
);
  localparam int         NUM_LANES = 3;
  localparam logic [3:0] DEB_LAST  = 4'(DEB_CYCLES - 1);
  localparam logic [3:0] FA_LAST   = 4'(FA_DEB - 1);
  localparam logic [7:0] HOLD_LAST = 8'(FA_HOLD - 1);
  localparam logic [6:0] TMAX      = 7'(T_MAX);
  localparam logic [6:0] TINIT     = 7'(T_INIT);
  localparam logic [8:0] SUM_INIT  = 9'(4 * T_INIT);

  // Two-flop synchronizers, bit order {fa, w, rd, fd}
  logic [3:0] sync1, sync2;

  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {raw_fa, raw_w, raw_rd, raw_fd};
      sync2 <= sync1;
    end
  end

  logic [NUM_LANES-1:0] deb_q;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_deb
    sensor_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk (clk),
      .rst (Rst),
      .s   (sync2[i]),
      .q   (deb_q[i])
    );
  end

  assign SFD = deb_q[0];
  assign SRD = deb_q[1];
  assign SW  = deb_q[2];

  // Fire alarm: fa_cnt counts rise-stable cycles while low, quiet cycles while high.
  logic       s_fa;
  logic [3:0] fa_cnt;
  logic [7:0] hold_cnt;

  assign s_fa = sync2[3];

  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      SFA      <= 1'b0;
      fa_cnt   <= '0;
      hold_cnt <= '0;
    end else if (!SFA) begin
      hold_cnt <= '0;
      if (!s_fa) begin
        fa_cnt <= '0;
      end else if (fa_cnt == FA_LAST) begin
        SFA    <= 1'b1;
        fa_cnt <= '0;
      end else begin
        fa_cnt <= fa_cnt + 4'd1;
      end
    end else begin
      if (hold_cnt != HOLD_LAST) hold_cnt <= hold_cnt + 8'd1;
      if (s_fa) begin
        fa_cnt <= '0;
      end else if (fa_cnt == DEB_LAST) begin
        // quiet long enough; park here until the hold time has run out
        if (hold_cnt == HOLD_LAST) begin
          SFA    <= 1'b0;
          fa_cnt <= '0;
        end
      end else begin
        fa_cnt <= fa_cnt + 4'd1;
      end
    end
  end

  typedef enum logic [1:0] {IDLE, ACCEPT, REJECT} tstate_t;

  tstate_t          state, nxt;
  logic [6:0]       samp;
  logic [3:0][6:0]  tbuf;
  logic [1:0]       ptr;
  logic [8:0]       sum;
  logic [1:0]       rej;
  logic             upd;

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (temp_valid) nxt = (raw_temp > TMAX) ? REJECT : ACCEPT;
      ACCEPT:  nxt = IDLE;
      REJECT:  nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      state      <= IDLE;
      samp       <= '0;
      tbuf       <= {4{TINIT}};
      ptr        <= '0;
      sum        <= SUM_INIT;
      rej        <= '0;
      upd        <= 1'b0;
      temp_fault <= 1'b0;
      ST         <= TINIT;
    end else begin
      state <= nxt;
      upd   <= 1'b0;
      if (state == IDLE && temp_valid) samp <= raw_temp;
      case (state)
        ACCEPT: begin
          tbuf[ptr]  <= samp;
          ptr        <= ptr + 2'd1;
          sum        <= sum - {2'b00, tbuf[ptr]} + {2'b00, samp};
          rej        <= '0;
          temp_fault <= 1'b0;
          upd        <= 1'b1;
        end
        REJECT: begin
          if (rej != 2'd3) rej <= rej + 2'd1;
          temp_fault <= (rej >= 2'd2);
        end
        default: ;
      endcase
      if (upd && !temp_fault) ST <= sum[8:2];
    end
  end
endmodule

// File: tb/tb_smart_home_sensor_cond.sv
// Directed bench for smart_home_sensor_cond: debounce latency/glitch, fire-alarm
// hold behaviour, temperature averaging, fault handling and reset.

module tb_smart_home_sensor_cond;
  logic       clk = 1'b0;
  logic       Rst;
  logic       raw_fd, raw_rd, raw_w, raw_fa;
  logic [6:0] raw_temp;
  logic       temp_valid;
  logic       SFD, SRD, SW, SFA;
  logic [6:0] ST;
  logic       temp_fault;

  int checks = 0;
  int errors = 0;
  int hist[$];

  smart_home_sensor_cond dut (
    .clk        (clk),
    .Rst        (Rst),
    .raw_fd     (raw_fd),
    .raw_rd     (raw_rd),
    .raw_w      (raw_w),
    .raw_fa     (raw_fa),
    .raw_temp   (raw_temp),
    .temp_valid (temp_valid),
    .SFD        (SFD),
    .SRD        (SRD),
    .SW         (SW),
    .SFA        (SFA),
    .ST         (ST),
    .temp_fault (temp_fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance n rising edges; land 1ns after the last one.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Mean of the last four accepted samples (reset preloads four T_INIT).
  function automatic logic [8:0] model_st();
    int s = 0;
    for (int i = 0; i < 4; i++) s += hist[hist.size() - 1 - i];
    return 9'(s >> 2);
  endfunction

  // One strobe; returns 3 edges later, when ST has just been updated.
  task automatic send(input logic [6:0] t);
    temp_valid = 1'b1;
    raw_temp   = t;
    step(1);
    temp_valid = 1'b0;
    step(2);
    if (t <= 7'd100) hist.push_back(int'(t));
  endtask

  initial begin
    Rst = 1'b1;
    raw_fd = 1'b0; raw_rd = 1'b0; raw_w = 1'b0; raw_fa = 1'b0;
    raw_temp = '0; temp_valid = 1'b0;
    hist = {60, 60, 60, 60};
    #2;
    check("rst_ST", ST, 60);
    step(2);
    Rst = 1'b0;
    check("rst_SFD", SFD, 0);
    check("rst_SRD", SRD, 0);
    check("rst_SW", SW, 0);
    check("rst_SFA", SFA, 0);
    check("rst_fault", temp_fault, 0);
    check("rst_ST_rel", ST, 60);

    // Door: exactly 6 cycles from raw edge to SFD edge
    raw_fd = 1'b1;
    step(5);
    check("sfd_lat5", SFD, 0);
    step(1);
    check("sfd_lat6", SFD, 1);

    // Window: 3-cycle pulse is filtered
    raw_w = 1'b1;
    step(3);
    raw_w = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step(1);
      check("sw_glitch", SW, 0);
    end

    // Fire alarm: short pulse, held for FA_HOLD, drops at cycle 20
    raw_fa = 1'b1;
    step(3);
    check("sfa_e3", SFA, 0);
    raw_fa = 1'b0;
    step(1);
    check("sfa_e4", SFA, 1);
    step(15);
    check("sfa_e19", SFA, 1);
    step(1);
    check("sfa_e20", SFA, 0);
    step(2);

    // Re-rise inside hold window does not restart the hold timer
    raw_fa = 1'b1;
    step(4);
    check("sfa2_e4", SFA, 1);
    step(1);
    raw_fa = 1'b0;
    step(3);
    raw_fa = 1'b1;
    step(2);
    raw_fa = 1'b0;
    step(9);
    check("sfa2_e19", SFA, 1);
    step(1);
    check("sfa2_e20", SFA, 0);
    step(2);

    // After hold: a 2-cycle dropout is ignored; a real drop takes 4 quiet cycles
    raw_fa = 1'b1;
    step(4);
    check("sfa3_e4", SFA, 1);
    step(21);
    raw_fa = 1'b0;
    step(2);
    raw_fa = 1'b1;
    step(13);
    check("sfa3_glitch", SFA, 1);
    raw_fa = 1'b0;
    step(5);
    check("sfa3_e45", SFA, 1);
    step(1);
    check("sfa3_e46", SFA, 0);

    // Temperature: first sample latency is 3 cycles
    temp_valid = 1'b1;
    raw_temp   = 7'd80;
    step(1);
    temp_valid = 1'b0;
    step(1);
    check("st_lat2", ST, 60);
    step(1);
    check("st_80a", ST, 65);
    hist.push_back(80);
    send(7'd80); check("st_80b", ST, 70);
    send(7'd80); check("st_80c", ST, 75);
    send(7'd80); check("st_80d", ST, 80);
    send(7'd81); check("st_81_trunc", ST, 80);

    // Three implausible samples raise the fault and freeze ST
    send(7'd120); check("fault_1", temp_fault, 0);
    send(7'd120); check("fault_2", temp_fault, 0);
    send(7'd120); check("fault_3", temp_fault, 1);
    check("st_frozen", ST, 80);
    send(7'd40);
    check("fault_clr", temp_fault, 0);
    check("st_40", ST, 70);

    // Pointer wrap and T_MAX boundary against the model
    send(7'd10);  check("st_m10", ST, model_st());
    send(7'd100); check("st_m100", ST, model_st());
    send(7'd101); check("st_m101_rej", ST, model_st());
    send(7'd0);   check("st_m0", ST, model_st());
    send(7'd127); check("st_m127_rej", ST, model_st());
    send(7'd55);  check("st_m55", ST, model_st());
    check("fault_partial", temp_fault, 0);
    send(7'd99);  check("st_m99", ST, model_st());

    // Strobe held into ACCEPT: second cycle is dropped
    temp_valid = 1'b1;
    raw_temp   = 7'd20;
    step(1);
    raw_temp   = 7'd0;
    step(1);
    temp_valid = 1'b0;
    step(2);
    hist.push_back(20);
    check("drop_a", ST, model_st());
    step(3);
    check("drop_b", ST, model_st());

    // Reset mid-debounce with ST=80
    send(7'd80); send(7'd80); send(7'd80); send(7'd80);
    check("st_pre_rst", ST, 80);
    raw_rd = 1'b1;
    step(3);
    #2 Rst = 1'b1;
    #1;
    check("rst_mid_SRD", SRD, 0);
    check("rst_mid_SFD", SFD, 0);
    check("rst_mid_ST", ST, 60);
    step(1);
    Rst = 1'b0;
    hist = {60, 60, 60, 60};
    step(5);
    check("srd_rel5", SRD, 0);
    check("st_rel", ST, 60);
    step(1);
    check("srd_rel6", SRD, 1);

    // Reset during ACCEPT discards the sample
    temp_valid = 1'b1;
    raw_temp   = 7'd0;
    step(1);
    temp_valid = 1'b0;
    #2 Rst = 1'b1;
    #2 Rst = 1'b0;
    step(4);
    check("rst_accept_ST", ST, 60);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/smart_home_sensor_cond.md
SMART_HOME_SENSOR_COND -- requirements
Module: smart_home_sensor_cond

Interface
REQ-001 Parameter DEB_CYCLES, default 4: consecutive stable cycles required before a door/window output changes (range 2..15).
REQ-002 Parameter FA_DEB, default 2: consecutive stable cycles required before SFA asserts (range 1..DEB_CYCLES).
REQ-003 Parameter FA_HOLD, default 16: minimum cycles SFA stays high once asserted (range 1..255).
REQ-004 Parameter T_MAX, default 100: largest raw temperature accepted as a plausible reading.
REQ-005 Parameter T_INIT, default 60: temperature preloaded into every averaging slot at reset.
REQ-006 Port clk  input  1  single clock; all state updates on the rising edge.
REQ-007 Port Rst  input  1  reset, asynchronous and active-high.
REQ-008 Port raw_fd, raw_rd, raw_w, raw_fa  input  1 each  asynchronous front-door, rear-door, window and fire-alarm contacts.
REQ-009 Port raw_temp  input  7  temperature reading; meaningful only while temp_valid=1.
REQ-010 Port temp_valid  input  1  one-cycle strobe per new raw_temp reading; synchronous to clk.
REQ-011 Port SFD, SRD, SW, SFA  output  1 each  debounced sensor levels driving the controller stage.
REQ-012 Port ST  output  7  filtered temperature driving the controller stage.
REQ-013 Port temp_fault  output  1  sensor-fault flag.

Function
REQ-014 Each raw_* contact SHALL pass through a two-flop synchronizer; the synchronized value is s_x.
REQ-015 SFD, SRD and SW SHALL each have a 4-bit counter: it clears when s_x equals the output or when s_x changes; otherwise it increments, and the output toggles and the counter clears in the cycle the counter reaches DEB_CYCLES-1.
REQ-016 Latency from a clean raw edge to an output edge SHALL be exactly 2+DEB_CYCLES cycles.
REQ-017 A glitch shorter than DEB_CYCLES cycles after synchronization SHALL NOT change the output.
REQ-018 SFA SHALL assert after FA_DEB consecutive cycles of s_fa=1.
REQ-019 SFA SHALL deassert only when both hold: at least FA_HOLD cycles have elapsed since assertion, and s_fa has been 0 for DEB_CYCLES consecutive cycles.
REQ-020 A re-rise of s_fa while SFA=1 SHALL clear the deassert counter but SHALL NOT restart the hold timer.
REQ-021 The temperature FSM SHALL have three states: IDLE (wait for temp_valid), ACCEPT (write sample), REJECT (count bad sample). Both ACCEPT and REJECT return to IDLE after one cycle.
REQ-022 On temp_valid, raw_temp SHALL be registered. A sample <= T_MAX goes to ACCEPT; a sample > T_MAX goes to REJECT.
REQ-023 ACCEPT SHALL write the sample into a 4-entry circular buffer at a 2-bit write pointer and then increment the pointer, wrapping 3->0.
REQ-024 ACCEPT SHALL update a 9-bit running sum as sum - oldest + sample. ST SHALL be sum>>2 (truncating), registered and updated the cycle after ACCEPT. Total latency is 3 cycles from temp_valid to the ST change.
REQ-025 A 2-bit reject counter SHALL increment in REJECT, saturating at 3, and clear in ACCEPT. temp_fault SHALL be 1 while the counter equals 3.
REQ-026 While temp_fault=1, ST SHALL hold its last value. temp_fault SHALL clear on the first ACCEPT.
REQ-027 temp_valid asserted while the FSM is not in IDLE SHALL be dropped. Sources must space strobes at least 3 cycles apart.
REQ-028 All outputs SHALL be registered; there is no combinational path from any input to any output.

Reset
REQ-029 Rst=1 SHALL immediately and asynchronously force the following values:
- SFD=SRD=SW=SFA=0 and temp_fault=0;
- ST=T_INIT, all four buffer slots = T_INIT, sum = 4*T_INIT;
- pointer = 0, all counters and synchronizers = 0, FSM = IDLE.
REQ-030 Reset asserted mid-debounce or mid-ACCEPT SHALL discard the pending change. The first valid update follows release with the full latency.
REQ-031 Reset release SHALL be synchronized to clk by the system. The block does no internal reset synchronization.

Verification
REQ-032 raw_fd 0->1 held high, default parameters -> SFD=1 exactly 6 cycles later. A 3-cycle pulse on raw_w -> SW stays 0.
REQ-033 raw_fa high for 3 cycles then low -> SFA=1 at cycle 4, held until at least cycle 4+16, then drops only after 4 quiet cycles.
REQ-034 Four accepted samples 80,80,80,80 after reset -> ST steps 65,70,75,80, each 3 cycles after its strobe. Sample 81 after that -> ST=80 (truncation).
REQ-035 Three samples of 120 -> temp_fault=1 after the third, ST unchanged. Next sample 40 -> temp_fault=0 and ST updated.
REQ-036 Rst pulse while SRD is mid-debounce and ST=80 -> SRD=0 and ST=60 immediately, with no pending change applied after release.
REQ-037 Write-pointer wrap: after 5 accepted samples, the oldest (first) sample is evicted from the sum -> ST matches the mean of the last four, checked against a reference model.
